// File: rtl/gcbp_pkg.sv
// Shared definitions for the GCBP BRAM write sequencer: FSM encoding,
// default tile geometry and the index-width helper.
package gcbp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } gcbp_state_e;

   localparam int DEF_H_TILES = 4;
   localparam int DEF_V_TILES = 4;
   localparam int DEF_TILE_W  = 64;
   localparam int DEF_TILE_H  = 64;
   localparam int DEF_DATA_W  = 8;

   // Bits needed to index n items; never less than one.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gcbp_tile_onehot_dec.sv
// Tile coordinate (h, v) to one-hot BRAM select; bit index is v*H_TILES+h.
module gcbp_tile_onehot_dec #(
   parameter int H_TILES = 4,
   parameter int V_TILES = 4,
   parameter int HW      = 3,
   parameter int VW      = 3
) (
   input  logic [HW-1:0]              h,
   input  logic [VW-1:0]              v,
   input  logic                       en,
   output logic [H_TILES*V_TILES-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int vi = 0; vi < V_TILES; vi++) begin
         for (int hi = 0; hi < H_TILES; hi++) begin
            onehot[vi*H_TILES+hi] = en && (h == HW'(hi)) && (v == VW'(vi));
         end
      end
   end

endmodule

// File: rtl/gcbp_bram_write_sequencer.sv
// Scatters a raster pixel stream into an H_TILES x V_TILES array of tile BRAMs.
// Optional macro GCBP_TILE_MASK_EN adds i_tile_mask to suppress writes per tile.
module gcbp_bram_write_sequencer
   import gcbp_pkg::*;
#(
   parameter int H_TILES = DEF_H_TILES,
   parameter int V_TILES = DEF_V_TILES,
   parameter int TILE_W  = DEF_TILE_W,
   parameter int TILE_H  = DEF_TILE_H,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_pix_valid,
   input  logic [DATA_W-1:0]                 i_pix_data,
   input  logic                              i_sof,
   input  logic                              i_eol,
`ifdef GCBP_TILE_MASK_EN
   input  logic [H_TILES*V_TILES-1:0]        i_tile_mask,
`endif
   output logic [H_TILES*V_TILES-1:0]        o_bram_wea,
   output logic [idx_w(TILE_W*TILE_H)-1:0]   o_bram_addr,
   output logic [DATA_W-1:0]                 o_bram_din,
   output logic                              o_frame_done,
   output logic                              o_busy
);

   localparam int LW       = $clog2(TILE_W);
   localparam int LH       = $clog2(TILE_H);
   localparam int COL_MAX  = H_TILES * TILE_W;
   localparam int LINE_MAX = V_TILES * TILE_H;
   // One spare bit so the column can park at COL_MAX and the line at LINE_MAX.
   localparam int CW       = idx_w(COL_MAX) + 1;
   localparam int RW       = idx_w(LINE_MAX) + 1;
   localparam int NT       = H_TILES * V_TILES;

   gcbp_state_e   state, state_nxt;
   logic [CW-1:0] col, col_nxt, col_p0;
   logic [RW-1:0] line, line_nxt, line_p0;
   logic          take_p0, in_rng_p0, last_p0;
   logic [NT-1:0] onehot_p0, wr_mask;

`ifdef GCBP_TILE_MASK_EN
   assign wr_mask = i_tile_mask;
`else
   assign wr_mask = '1;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
         col   <= '0;
         line  <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         line  <= line_nxt;
      end
   end

   // Stage p0: effective coordinate of the incoming pixel (SOF forces 0,0)
   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      line_nxt  = line;
      col_p0    = i_sof ? '0 : col;
      line_p0   = i_sof ? '0 : line;
      take_p0   = i_pix_valid && (i_sof || (state == ST_ACTIVE));
      in_rng_p0 = (col_p0 < CW'(COL_MAX)) && (line_p0 < RW'(LINE_MAX));
      last_p0   = take_p0 && i_eol && (line_p0 == RW'(LINE_MAX - 1));
      if (take_p0) begin
         if (i_eol) begin
            col_nxt  = '0;
            line_nxt = line_p0 + 1'b1;
         end else begin
            col_nxt  = (col_p0 == CW'(COL_MAX)) ? col_p0 : col_p0 + 1'b1;
            line_nxt = line_p0;
         end
         state_nxt = last_p0 ? ST_DONE : ST_ACTIVE;
      end
   end

   gcbp_tile_onehot_dec #(
      .H_TILES (H_TILES),
      .V_TILES (V_TILES),
      .HW      (CW - LW),
      .VW      (RW - LH)
   ) u_dec (
      .h      (col_p0[CW-1:LW]),
      .v      (line_p0[RW-1:LH]),
      .en     (take_p0 && in_rng_p0),
      .onehot (onehot_p0)
   );

   // Stage p1: registered BRAM write port
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_bram_wea   <= '0;
         o_bram_addr  <= '0;
         o_bram_din   <= '0;
         o_frame_done <= 1'b0;
      end else begin
         o_bram_wea   <= onehot_p0 & wr_mask;
         o_bram_addr  <= {line_p0[LH-1:0], col_p0[LW-1:0]};
         o_bram_din   <= i_pix_data;
         o_frame_done <= last_p0;
      end
   end

   assign o_busy = (state == ST_ACTIVE);

endmodule

// File: tb/tb_gcbp_bram_write_sequencer.sv
// Self-checking bench for gcbp_bram_write_sequencer at default geometry;
// honours GCBP_TILE_MASK_EN by driving mask 16'hFFFE.
module tb_gcbp_bram_write_sequencer;

   localparam int H  = 4;
   localparam int V  = 4;
   localparam int TW = 64;
   localparam int TH = 64;
   localparam int NT = H * V;
`ifdef GCBP_TILE_MASK_EN
   localparam logic [NT-1:0] MASK = 16'hFFFE;
`else
   localparam logic [NT-1:0] MASK = 16'hFFFF;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_valid;
   logic [7:0]    pix_data;
   logic          sof;
   logic          eol;
   logic [NT-1:0] tile_mask;
   logic [NT-1:0] bram_wea;
   logic [11:0]   bram_addr;
   logic [7:0]    bram_din;
   logic          frame_done;
   logic          busy;

   always #5 clk = ~clk;

   gcbp_bram_write_sequencer #(
      .H_TILES (H), .V_TILES (V), .TILE_W (TW), .TILE_H (TH), .DATA_W (8)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_pix_valid  (pix_valid),
      .i_pix_data   (pix_data),
      .i_sof        (sof),
      .i_eol        (eol),
`ifdef GCBP_TILE_MASK_EN
      .i_tile_mask  (tile_mask),
`endif
      .o_bram_wea   (bram_wea),
      .o_bram_addr  (bram_addr),
      .o_bram_din   (bram_din),
      .o_frame_done (frame_done),
      .o_busy       (busy)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame position as plain integers, tile and address by division.
   int            m_col = 0, m_line = 0, cyc = 0;
   bit            m_in = 0, mvalid = 0, probe = 0, probe_d = 0;
   logic [NT-1:0] e_wea = '0;
   int            e_addr = 0;
   logic [7:0]    e_din = '0;
   bit            e_done = 0, e_busy = 0;

   always @(posedge clk) begin
      cyc++;
      probe_d = probe;
      if (rst) begin
         m_in = 0; m_col = 0; m_line = 0;
         e_wea = '0; e_addr = 0; e_din = '0; e_done = 0;
         mvalid = 1;
      end else begin
         e_din  = pix_data;
         e_wea  = '0;
         e_done = 0;
         if (pix_valid && (sof || m_in)) begin
            if (sof) begin m_col = 0; m_line = 0; end
            m_in   = 1;
            e_addr = (m_line % TH) * TW + (m_col % TW);
            if (m_col < H*TW && m_line < V*TH)
               e_wea = MASK & (NT'(1) << ((m_line / TH) * H + m_col / TW));
            if (eol && m_line == V*TH - 1) begin e_done = 1; m_in = 0; end
            if (eol) begin m_col = 0; m_line++; end
            else if (m_col < H*TW) m_col++;
         end
      end
      e_busy = m_in;
   end

   int            wr_total = 0, done_cnt = 0, done_cyc = 0;
   int            cnt [NT];
   logic [NT-1:0] probe_wea;
   logic [11:0]   probe_addr;

   always @(negedge clk) begin
      if (mvalid) begin
         chk("wea", 32'(bram_wea), 32'(e_wea));
         if (e_wea != '0) chk("addr", 32'(bram_addr), 32'(e_addr));
         chk("din", 32'(bram_din), 32'(e_din));
         chk("frame_done", 32'(frame_done), 32'(e_done));
         chk("busy", 32'(busy), 32'(e_busy));
         for (int b = 0; b < NT; b++) if (bram_wea[b]) cnt[b]++;
         if (bram_wea != '0) wr_total++;
         if (frame_done) begin done_cnt++; done_cyc = cyc; end
         if (probe_d) begin probe_wea = bram_wea; probe_addr = bram_addr; end
      end
   end

   task automatic px(input logic v, input logic [7:0] d, input logic s, input logic e,
                     input bit pr = 0);
      pix_valid = v; pix_data = d; sof = s; eol = e; probe = pr;
      @(posedge clk); #1;
   endtask

   task automatic send_line(input int n, input bit first_sof, input int ln);
      for (int i = 0; i < n; i++) px(1'b1, 8'(i ^ ln), first_sof && i == 0, i == n - 1);
   endtask

   int base_wr, base_done, last_cyc;

   initial begin
      tile_mask = MASK;
      for (int b = 0; b < NT; b++) cnt[b] = 0;
      rst = 1'b1; pix_valid = 1'b1; pix_data = 8'hA5; sof = 1'b1; eol = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wea", 32'(bram_wea), 32'd0);
      chk("rst_addr", 32'(bram_addr), 32'd0);
      chk("rst_din", 32'(bram_din), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // No SOF yet: nothing may be written.
      base_wr = wr_total;
      for (int i = 0; i < 5; i++) px(1'b1, 8'(i), 1'b0, i == 2);
      px(1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_nowrite", 32'(wr_total - base_wr), 32'd0);

      // Aborted frame: 100 short lines, then SOF restarts into a full frame.
      base_done = done_cnt;
      send_line(4, 1, 0);
      for (int ln = 1; ln < 100; ln++) send_line(4, 0, ln);
      px(1'b0, 8'h00, 1'b0, 1'b0);
      chk("abort_no_done", 32'(done_cnt - base_done), 32'd0);
      base_wr = wr_total;
      for (int b = 0; b < NT; b++) cnt[b] = 0;
      for (int ln = 0; ln < 256; ln++)
         for (int i = 0; i < 256; i++) begin
            if (ln == 255 && i == 255) last_cyc = cyc;
            px(1'b1, 8'(i + ln), ln == 0 && i == 0, i == 255, ln == 130 && i == 70);
         end
      px(1'b0, 8'h00, 1'b0, 1'b0);
      chk("frame_writes", 32'(wr_total - base_wr), 32'(4096 * $countones(MASK)));
      for (int b = 0; b < NT; b++) chk($sformatf("bit%0d_writes", b), 32'(cnt[b]), MASK[b] ? 32'd4096 : 32'd0);
      chk("frame_done_once", 32'(done_cnt - base_done), 32'd1);
      chk("done_latency", 32'(done_cyc - last_cyc), 32'd1);
      chk("probe_70_130_wea", 32'(probe_wea), 32'h0200);
      chk("probe_70_130_addr", 32'(probe_addr), 32'd134);

      // DONE state ignores pixels without SOF.
      base_wr = wr_total;
      for (int i = 0; i < 3; i++) px(1'b1, 8'(i), 1'b0, 1'b0);
      px(1'b0, 8'h00, 1'b0, 1'b0);
      chk("done_nowrite", 32'(wr_total - base_wr), 32'd0);

      // 300-pixel line: only columns 0..255 are written, next line restarts at column 0.
      base_wr = wr_total;
      send_line(300, 1, 0);
      px(1'b0, 8'h00, 1'b0, 1'b0);
      chk("long_line_writes", 32'(wr_total - base_wr), 32'(64 * $countones(MASK[3:0])));
      px(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
      px(1'b0, 8'h00, 1'b0, 1'b0);
      chk("after_long_addr", 32'(probe_addr), 32'd64);
      chk("after_long_wea", 32'(probe_wea), 32'(MASK & 16'h0001));

      // SOF together with EOL: one-pixel line, next pixel at column 0 line 1.
      px(1'b1, 8'h11, 1'b1, 1'b1);
      px(1'b1, 8'h22, 1'b0, 1'b0, 1'b1);
      px(1'b0, 8'h00, 1'b0, 1'b0);
      chk("sof_eol_next_addr", 32'(probe_addr), 32'd64);

      // Reset at line 50 discards the frame.
      send_line(4, 1, 0);
      for (int ln = 1; ln < 50; ln++) send_line(4, 0, ln);
      px(1'b1, 8'h50, 1'b0, 1'b0);
      rst = 1'b1;
      px(1'b1, 8'h51, 1'b0, 1'b0);
      rst = 1'b0;
      base_wr = wr_total;
      for (int i = 0; i < 20; i++) px(1'b1, 8'(i), 1'b0, i % 5 == 4);
      @(negedge clk);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("rst_mid_nowrite", 32'(wr_total - base_wr), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
